// File: rtl/cmd_digit_scheduler_if.sv
// Request/command bus between the digit requesters and the command-digit scheduler.
// Requesters hold iREQ until they see their oGNT pulse; the scheduler owns all o* signals.
interface cmd_digit_scheduler_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   iREQ;
   logic [4*NREQ-1:0] iREQ_DIG;
   logic              iABORT;
   logic [NREQ-1:0]   oGNT;
   logic [3:0]        oDIG;
   logic              oVALID;
   logic              oBUSY;
   logic              oERR;

   modport master (
      output iREQ, iREQ_DIG, iABORT,
      input  oGNT, oDIG, oVALID, oBUSY, oERR
   );

   modport slave (
      input  iREQ, iREQ_DIG, iABORT,
      output oGNT, oDIG, oVALID, oBUSY, oERR
   );
endinterface

// File: rtl/cmd_digit_scheduler.sv
// Round-robin sharer of the encoder command digit: grant -> hold HOLD_CYCLES -> IDLE_DIG gap.
// Grant is one edge after a request in IDLE; requests arriving in HOLD/GAP simply wait (not queued).
module cmd_digit_scheduler #(
   parameter int         NREQ        = 4,
   parameter int         HOLD_CYCLES = 1000,
   parameter int         GAP_CYCLES  = 2,
   parameter logic [3:0] IDLE_DIG    = 4'h8
)(
   input  logic                 iCLK,
   input  logic                 iRST,
   cmd_digit_scheduler_if.slave bus
);

   localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int PW   = $clog2(NREQ);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_GAP
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [PW-1:0]   r_ptr;
   logic [NREQ-1:0] r_gnt;
   logic [3:0]      r_dig;
   logic            r_valid;
   logic            r_busy;
   logic            r_err;

   logic            w_found;
   logic [PW-1:0]   w_win;
   logic [PW:0]     w_sum;
   logic [3:0]      w_dig;
   logic            w_legal;
   logic [PW-1:0]   w_ptr_nxt;

   // Search ptr, ptr+1, ... (mod NREQ) for the first active request.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_sum = {1'b0, r_ptr} + (PW+1)'(i);
         if (w_sum >= (PW+1)'(NREQ)) begin
            w_sum = w_sum - (PW+1)'(NREQ);
         end
         if (!w_found && bus.iREQ[w_sum[PW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_sum[PW-1:0];
         end
      end
   end

   assign w_dig     = bus.iREQ_DIG[{w_win, 2'b00} +: 4];
   assign w_legal   = (w_dig >= 4'd1) && (w_dig <= 4'd8);
   assign w_ptr_nxt = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_dig   <= IDLE_DIG;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_gnt <= '0;
         r_err <= 1'b0;
         if (bus.iABORT) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dig   <= IDLE_DIG;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_found) begin
                     r_gnt <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                     r_ptr <= w_ptr_nxt;
                     if (w_legal) begin
                        r_state <= S_HOLD;
                        r_cnt   <= HOLD_LOAD;
                        r_dig   <= w_dig;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                     end else begin
                        // Illegal digits are consumed here and never reach the encoder.
                        r_err <= 1'b1;
                     end
                  end
               end
               S_HOLD: begin
                  if (r_cnt == '0) begin
                     r_dig   <= IDLE_DIG;
                     r_valid <= 1'b0;
                     if (GAP_CYCLES == 0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state <= S_GAP;
                        r_cnt   <= GAP_LOAD;
                     end
                  end else begin
                     r_cnt <= r_cnt - CW'(1);
                  end
               end
               S_GAP: begin
                  if (r_cnt == '0) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt - CW'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_dig   <= IDLE_DIG;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.oGNT   = r_gnt;
   assign bus.oDIG   = r_dig;
   assign bus.oVALID = r_valid;
   assign bus.oBUSY  = r_busy;
   assign bus.oERR   = r_err;

endmodule

// File: tb/tb_cmd_digit_scheduler.sv
// Scoreboard bench for cmd_digit_scheduler (NREQ=4, HOLD=4, GAP=2, IDLE_DIG=8).
module tb_cmd_digit_scheduler;

   logic iCLK;
   logic iRST;

   cmd_digit_scheduler_if #(.NREQ(4)) bus ();

   cmd_digit_scheduler #(
      .NREQ(4), .HOLD_CYCLES(4), .GAP_CYCLES(2), .IDLE_DIG(4'h8)
   ) dut (
      .iCLK(iCLK),
      .iRST(iRST),
      .bus (bus)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   typedef struct {
      logic [3:0] gnt;
      logic       err;
   } gexp_t;

   typedef struct {
      logic [3:0] dig;
      int         len;
      int         gap;
   } hexp_t;

   gexp_t q_g[$];
   hexp_t q_h[$];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge iCLK);
      #1;
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 40; k++) begin
         if (!bus.oBUSY) break;
         cyc(1);
      end
      if (k == 40) chk("wait_idle_timeout", 1, 0);
   endtask

   task automatic push_g(input logic [3:0] g, input logic e);
      gexp_t x;
      x.gnt = g;
      x.err = e;
      q_g.push_back(x);
   endtask

   task automatic push_h(input logic [3:0] d, input int l, input int gp);
      hexp_t x;
      x.dig = d;
      x.len = l;
      x.gap = gp;
      q_h.push_back(x);
   endtask

   // Monitor: pops expectations whenever the DUT grants or finishes a hold.
   logic       m_prev_v = 1'b0;
   logic       m_gap_arm = 1'b0;
   logic [3:0] m_dig = 4'h0;
   int         m_len = 0;
   int         m_gap = 0;
   int         m_gexp = 0;

   always @(negedge iCLK) begin
      gexp_t g;
      hexp_t h;
      if (iRST) begin
         m_prev_v  = 1'b0;
         m_gap_arm = 1'b0;
      end else begin
         if (bus.oGNT != 4'b0) begin
            if (q_g.size() == 0) begin
               chk("unexpected_gnt", int'(bus.oGNT), 0);
            end else begin
               g = q_g.pop_front();
               chk("gnt", int'(bus.oGNT), int'(g.gnt));
               chk("err", int'(bus.oERR), int'(g.err));
            end
         end else if (bus.oERR) begin
            chk("err_without_gnt", 1, 0);
         end

         if (bus.oVALID && !m_prev_v) begin
            if (m_gap_arm) begin
               chk("no_idle_before_grant", m_gap, m_gexp + 1000);
               m_gap_arm = 1'b0;
            end
            m_dig = bus.oDIG;
            m_len = 1;
         end else if (bus.oVALID) begin
            m_len++;
            if (bus.oDIG != m_dig) chk("dig_unstable", int'(bus.oDIG), int'(m_dig));
         end else if (m_prev_v) begin
            if (q_h.size() == 0) begin
               chk("unexpected_hold", int'(m_dig), 0);
            end else begin
               h = q_h.pop_front();
               chk("hold_dig", int'(m_dig), int'(h.dig));
               chk("hold_len", m_len, h.len);
               chk("idle_dig_after_hold", int'(bus.oDIG), 8);
               if (!bus.oBUSY) begin
                  chk("gap_len", 0, h.gap);
               end else begin
                  m_gap_arm = 1'b1;
                  m_gap     = 1;
                  m_gexp    = h.gap;
               end
            end
         end else if (m_gap_arm) begin
            if (bus.oBUSY) begin
               m_gap++;
               if (bus.oDIG != 4'h8) chk("gap_dig", int'(bus.oDIG), 8);
            end else begin
               chk("gap_len", m_gap, m_gexp);
               m_gap_arm = 1'b0;
            end
         end
         m_prev_v = bus.oVALID;
      end
   end

   initial begin
      iRST         = 1'b0;
      bus.iREQ     = 4'b0;
      bus.iREQ_DIG = 16'h0;
      bus.iABORT   = 1'b0;
      #1 iRST = 1'b1;
      #2;
      chk("rst_dig", int'(bus.oDIG), 8);
      chk("rst_valid", int'(bus.oVALID), 0);
      chk("rst_busy", int'(bus.oBUSY), 0);
      chk("rst_gnt", int'(bus.oGNT), 0);
      chk("rst_err", int'(bus.oERR), 0);
      cyc(2);
      iRST = 1'b0;
      cyc(1);

      // Single request, digit 5 on requester 0.
      push_g(4'b0001, 1'b0);
      push_h(4'h5, 4, 2);
      bus.iREQ_DIG = 16'h0005;
      bus.iREQ     = 4'b0001;
      cyc(1);
      bus.iREQ = 4'b0;
      wait_idle();
      cyc(1);

      // Reset mid-HOLD while requester 1 holds digit 3 (ptr is 1 here).
      push_g(4'b0010, 1'b0);
      bus.iREQ_DIG = 16'h0030;
      bus.iREQ     = 4'b0010;
      cyc(1);
      bus.iREQ = 4'b0;
      cyc(1);
      chk("pre_rst_dig", int'(bus.oDIG), 3);
      #2 iRST = 1'b1;
      #1;
      chk("async_rst_dig", int'(bus.oDIG), 8);
      chk("async_rst_valid", int'(bus.oVALID), 0);
      chk("async_rst_busy", int'(bus.oBUSY), 0);
      chk("async_rst_gnt", int'(bus.oGNT), 0);
      cyc(2);
      iRST = 1'b0;
      cyc(1);

      // Round robin with all four requesting; ptr was reset so requester 0 goes first.
      push_g(4'b0001, 1'b0); push_h(4'h1, 4, 2);
      push_g(4'b0010, 1'b0); push_h(4'h2, 4, 2);
      push_g(4'b0100, 1'b0); push_h(4'h3, 4, 2);
      push_g(4'b1000, 1'b0); push_h(4'h4, 4, 2);
      push_g(4'b0001, 1'b0); push_h(4'h1, 4, 2);
      bus.iREQ_DIG = 16'h4321;
      bus.iREQ     = 4'b1111;
      cyc(29);
      bus.iREQ = 4'b0;
      wait_idle();
      cyc(1);

      // Illegal digits: requester 2 digit 0 (ptr 1 -> 3).
      push_g(4'b0100, 1'b1);
      bus.iREQ_DIG = 16'h0000;
      bus.iREQ     = 4'b0100;
      cyc(1);
      bus.iREQ = 4'b0;
      chk("illegal_dig_unchanged", int'(bus.oDIG), 8);
      chk("illegal_valid", int'(bus.oVALID), 0);
      chk("illegal_busy", int'(bus.oBUSY), 0);
      // ptr is 3, so requester 3 (digit 12) beats requester 2.
      push_g(4'b1000, 1'b1);
      bus.iREQ_DIG = 16'hC000;
      bus.iREQ     = 4'b1100;
      cyc(1);
      bus.iREQ = 4'b0;
      chk("illegal2_dig", int'(bus.oDIG), 8);
      cyc(1);
      // ptr wrapped to 0: requester 0 beats requester 3.
      push_g(4'b0001, 1'b0);
      push_h(4'h6, 4, 2);
      bus.iREQ_DIG = 16'hC006;
      bus.iREQ     = 4'b1001;
      cyc(1);
      bus.iREQ = 4'b0;
      wait_idle();
      cyc(1);

      // Abort in the 2nd HOLD cycle, then abort held against a pending request.
      push_g(4'b0010, 1'b0);
      push_h(4'h7, 2, 0);
      bus.iREQ_DIG = 16'h0070;
      bus.iREQ     = 4'b0010;
      cyc(1);
      bus.iREQ = 4'b0;
      cyc(1);
      bus.iABORT = 1'b1;
      cyc(1);
      chk("abort_dig", int'(bus.oDIG), 8);
      chk("abort_valid", int'(bus.oVALID), 0);
      chk("abort_busy", int'(bus.oBUSY), 0);
      bus.iREQ = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("abort_blocks_gnt", int'(bus.oGNT), 0);
      end
      push_g(4'b0010, 1'b0);
      push_h(4'h7, 4, 2);
      bus.iABORT = 1'b0;
      cyc(1);
      bus.iREQ = 4'b0;
      chk("post_abort_gnt", int'(bus.oGNT), 2);
      wait_idle();
      cyc(1);

      // Requester 1 raised during HOLD and withdrawn before IDLE: never granted.
      push_g(4'b0001, 1'b0);
      push_h(4'h2, 4, 2);
      bus.iREQ_DIG = 16'h0052;
      bus.iREQ     = 4'b0001;
      cyc(1);
      bus.iREQ = 4'b0;
      cyc(1);
      bus.iREQ = 4'b0010;
      cyc(2);
      bus.iREQ = 4'b0;
      wait_idle();
      cyc(3);

      // Requester 1 held into IDLE: granted on the first IDLE cycle.
      push_g(4'b0001, 1'b0); push_h(4'h2, 4, 2);
      push_g(4'b0010, 1'b0); push_h(4'h5, 4, 2);
      bus.iREQ = 4'b0001;
      cyc(1);
      bus.iREQ = 4'b0;
      cyc(1);
      bus.iREQ = 4'b0010;
      cyc(5);
      chk("first_idle_busy", int'(bus.oBUSY), 0);
      chk("first_idle_no_gnt", int'(bus.oGNT), 0);
      cyc(1);
      chk("late_req_gnt", int'(bus.oGNT), 2);
      bus.iREQ = 4'b0;
      wait_idle();
      cyc(5);

      chk("gnt_queue_drained", q_g.size(), 0);
      chk("hold_queue_drained", q_h.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
